// File: rtl/alui_fsm_if.sv
// Bus bundle for the ALU-immediate sequencer: instruction request in, register/ALU strobes out.
// The DUT connects through the slave modport; the bench or issuing logic uses master.
interface alui_fsm_if;
  logic        start;
  logic [3:0]  opCode;
  logic [5:0]  Ri;
  logic [5:0]  num;
  logic [15:0] out_to_bus;
  logic        done;
  logic        R0_write;
  logic        R1_write;
  logic        R2_write;
  logic        R3_write;
  logic        R0_read;
  logic        R1_read;
  logic        R2_read;
  logic        R3_read;
  logic [2:0]  ALU_opControl;
  logic        ALU_alu_out_en;
  logic        ALU_writeIN1;
  logic        ALU_writeIN2;
  logic        ALU_read;

  modport master (
    output start, opCode, Ri, num,
    input  out_to_bus, done,
    input  R0_write, R1_write, R2_write, R3_write,
    input  R0_read, R1_read, R2_read, R3_read,
    input  ALU_opControl, ALU_alu_out_en, ALU_writeIN1, ALU_writeIN2, ALU_read
  );

  modport slave (
    input  start, opCode, Ri, num,
    output out_to_bus, done,
    output R0_write, R1_write, R2_write, R3_write,
    output R0_read, R1_read, R2_read, R3_read,
    output ALU_opControl, ALU_alu_out_en, ALU_writeIN1, ALU_writeIN2, ALU_read
  );
endinterface

// File: rtl/alui_fsm.sv
// Sequencer for one ALU-immediate instruction: fetch Rx, drive immediate, execute, write back.
// Define ALUI_SIGN_EXT_EN to sign-extend the 6-bit immediate; otherwise it is zero-extended.
module alui_fsm (
  input  logic       clk,
  input  logic       reset,
  alui_fsm_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, IMM, EXEC, WB, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  opCode_q, opCode_d;
  logic [1:0]  regSel_q, regSel_d;
  logic [5:0]  num_q, num_d;

  logic [15:0] immExt;
  logic [3:0]  regOneHot;
  logic [15:0] outBus;
  logic        doneOut;
  logic [3:0]  regWrite;
  logic [3:0]  regRead;
  logic [2:0]  aluOp;
  logic        aluEn;
  logic        aluIn1;
  logic        aluIn2;
  logic        aluRead;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      opCode_q <= 3'd0;
      regSel_q <= 2'd0;
      num_q    <= 6'd0;
    end else begin
      state_q  <= state_d;
      opCode_q <= opCode_d;
      regSel_q <= regSel_d;
      num_q    <= num_d;
    end
  end

  // Only the low opcode bits and register select matter after capture; opCode[3] just picks the path.
  always_comb begin
    state_d  = state_q;
    opCode_d = opCode_q;
    regSel_d = regSel_q;
    num_d    = num_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opCode_d = bus.opCode[2:0];
          regSel_d = bus.Ri[1:0];
          num_d    = bus.num;
          state_d  = bus.opCode[3] ? DONE : FETCH;
        end
      end
      FETCH:   state_d = IMM;
      IMM:     state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ALUI_SIGN_EXT_EN
  assign immExt = {{10{num_q[5]}}, num_q};
`else
  assign immExt = {10'b0, num_q};
`endif

  assign regOneHot = 4'b0001 << regSel_q;

  always_comb begin
    outBus   = 16'h0000;
    doneOut  = 1'b0;
    regWrite = 4'b0000;
    regRead  = 4'b0000;
    aluOp    = 3'd0;
    aluEn    = 1'b0;
    aluIn1   = 1'b0;
    aluIn2   = 1'b0;
    aluRead  = 1'b0;
    case (state_q)
      FETCH: begin
        regRead = regOneHot;
        aluIn1  = 1'b1;
      end
      IMM: begin
        outBus = immExt;
        aluIn2 = 1'b1;
      end
      EXEC: begin
        aluOp = opCode_q;
        aluEn = 1'b1;
      end
      WB: begin
        aluOp    = opCode_q;
        aluRead  = 1'b1;
        regWrite = regOneHot;
      end
      DONE:    doneOut = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_to_bus     = outBus;
  assign bus.done           = doneOut;
  assign bus.R0_write       = regWrite[0];
  assign bus.R1_write       = regWrite[1];
  assign bus.R2_write       = regWrite[2];
  assign bus.R3_write       = regWrite[3];
  assign bus.R0_read        = regRead[0];
  assign bus.R1_read        = regRead[1];
  assign bus.R2_read        = regRead[2];
  assign bus.R3_read        = regRead[3];
  assign bus.ALU_opControl  = aluOp;
  assign bus.ALU_alu_out_en = aluEn;
  assign bus.ALU_writeIN1   = aluIn1;
  assign bus.ALU_writeIN2   = aluIn2;
  assign bus.ALU_read       = aluRead;

endmodule

// File: tb/tb_alui_fsm.sv
// Self-checking bench for alui_fsm: table of instructions walked phase by phase, plus
// hand-written reset-abort, reset-priority and back-to-back sequences.
module tb_alui_fsm;

  logic clk = 1'b0;
  logic reset;

  alui_fsm_if bus ();

  alui_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0]  opCode;
    logic [5:0]  Ri;
    logic [5:0]  num;
    logic [15:0] expBus;
    logic [3:0]  expReg;
    logic [2:0]  expOp;
    logic        legal;
  } vec_t;

  vec_t vecs[7];

  // Packed output layout: {bus16, done, Rw[3:0], Rr[3:0], opc[2:0], en, in1, in2, rd}.
  function automatic logic [31:0] mk(input logic [15:0] b, input logic d, input logic [3:0] rw,
                                     input logic [3:0] rr, input logic [2:0] opc, input logic en,
                                     input logic in1, input logic in2, input logic rd);
    return {b, d, rw, rr, opc, en, in1, in2, rd};
  endfunction

  function automatic logic [31:0] outVec();
    return {bus.out_to_bus, bus.done,
            bus.R3_write, bus.R2_write, bus.R1_write, bus.R0_write,
            bus.R3_read, bus.R2_read, bus.R1_read, bus.R0_read,
            bus.ALU_opControl, bus.ALU_alu_out_en, bus.ALU_writeIN1, bus.ALU_writeIN2, bus.ALU_read};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] exp);
    logic [31:0] act;
    act = outVec();
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Present an instruction for one capture edge, then scramble the inputs to prove they were latched.
  task automatic applyStimulus(input logic [3:0] op, input logic [5:0] ri, input logic [5:0] n);
    @(negedge clk);
    bus.opCode = op;
    bus.Ri     = ri;
    bus.num    = n;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.opCode = ~op;
    bus.Ri     = ~ri;
    bus.num    = ~n;
  endtask

  initial begin
    vec_t v;
`ifdef ALUI_SIGN_EXT_EN
    vecs[0] = '{4'd5, 6'd0,       6'h3F,      16'hFFFF, 4'b0001, 3'd5, 1'b1};
    vecs[2] = '{4'd1, 6'b111110,  6'b100000,  16'hFFE0, 4'b0100, 3'd1, 1'b1};
`else
    vecs[0] = '{4'd5, 6'd0,       6'h3F,      16'h003F, 4'b0001, 3'd5, 1'b1};
    vecs[2] = '{4'd1, 6'b111110,  6'b100000,  16'h0020, 4'b0100, 3'd1, 1'b1};
`endif
    vecs[1] = '{4'd2, 6'b000011,  6'd7,       16'h0007, 4'b1000, 3'd2, 1'b1};
    vecs[3] = '{4'd0, 6'b000001,  6'd0,       16'h0000, 4'b0010, 3'd0, 1'b1};
    vecs[4] = '{4'd7, 6'b101010,  6'h15,      16'h0015, 4'b0100, 3'd7, 1'b1};
    vecs[5] = '{4'd9, 6'b000011,  6'h3F,      16'h0000, 4'b0000, 3'd0, 1'b0};
    vecs[6] = '{4'hF, 6'b000000,  6'h01,      16'h0000, 4'b0000, 3'd0, 1'b0};

    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.opCode = 4'd0;
    bus.Ri     = 6'd0;
    bus.num    = 6'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset state", 32'h0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle no start", 32'h0);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      applyStimulus(v.opCode, v.Ri, v.num);
      if (v.legal) begin
        checkOutput($sformatf("v%0d FETCH", i), mk(16'h0, 1'b0, 4'b0, v.expReg, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput($sformatf("v%0d IMM", i), mk(v.expBus, 1'b0, 4'b0, 4'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        checkOutput($sformatf("v%0d EXEC", i), mk(16'h0, 1'b0, 4'b0, 4'b0, v.expOp, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput($sformatf("v%0d WB", i), mk(16'h0, 1'b0, v.expReg, 4'b0, v.expOp, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
      end
      checkOutput($sformatf("v%0d DONE", i), mk(16'h0, 1'b1, 4'b0, 4'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      checkOutput($sformatf("v%0d back to IDLE", i), 32'h0);
    end

    // Abort in EXEC: nothing may be written and no done may follow.
    applyStimulus(4'd5, 6'd0, 6'h3F);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort pre EXEC", mk(16'h0, 1'b0, 4'b0, 4'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort reset cycle", 32'h0);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("abort quiet %0d", c), 32'h0);
    end

    // Reset wins over a simultaneous start.
    bus.opCode = 4'd1;
    bus.Ri     = 6'd1;
    bus.num    = 6'd2;
    bus.start  = 1'b1;
    reset      = 1'b0;
    @(negedge clk);
    checkOutput("reset over start", 32'h0);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("idle after reset", 32'h0);

    // Start held high: one operation every six cycles; a mid-op toggle is ignored.
    bus.opCode = 4'd1;
    bus.Ri     = 6'd1;
    bus.num    = 6'd2;
    bus.start  = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      checkBit($sformatf("b2b done c%0d", c), bus.done, (c % 6) == 4);
      checkBit($sformatf("b2b R1_read c%0d", c), bus.R1_read, (c % 6) == 0);
      if (c == 2) bus.start = 1'b0;
      if (c == 3) bus.start = 1'b1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("final idle", 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
